// File: rtl/spin_pkg.sv
// Shared constants for the LED-spinner sequencer: state encoding and LFSR width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spin_pkg;

    localparam int STATE_W = 2;
    localparam int LFSR_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        FAST   = 2'd1,
        SLOW   = 2'd2,
        RESULT = 2'd3
    } state_e;

endpackage

// File: rtl/spin_ctrl_tick_gen.sv
// Tick generator: one-clock pulse every TICK_DIV clocks while not cleared.
// Latency: first tick is seen TICK_DIV clocks after clr_i drops.
// Backpressure: none; free-running, clr_i holds the counter at zero.
//
// Ports: clk_i/rst_ni clock and async active-low reset, clr_i synchronous
// hold-at-zero, tick_o pulse on the counter wrap.
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap   = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick_o = wrap && !clr_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spin_ctrl.sv
// LED-spinner sequencer: start edge -> FAST steps -> decelerating SLOW steps -> RESULT hold -> IDLE.
// Latency: outputs registered; first step FAST_PERIOD*TICK_DIV clocks after the start edge.
// Backpressure: none; start edges outside IDLE are dropped, never queued.
//
// Ports: clk_i/rst_ni clock and async active-low reset; start_i synchronised start
// request (rising edge); lfsr_i rng value captured on the start edge; rng_en_o lets
// the LFSR free-run while idle; led_o one-hot ring; result_o last landed position;
// busy_o high outside IDLE; done_o one-clock pulse on entering RESULT.
module spin_ctrl
    import spin_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int TICK_DIV    = 50000,
    parameter int FAST_PERIOD = 20,
    parameter int FAST_STEPS  = 32,
    parameter int SLOW_INC    = 8,
    parameter int MAX_PERIOD  = 200,
    parameter int HOLD_TICKS  = 2000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [LFSR_W-1:0]           lfsr_i,
    output logic                        rng_en_o,
    output logic [NUM_LEDS-1:0]         led_o,
    output logic [$clog2(NUM_LEDS)-1:0] result_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int POS_W    = $clog2(NUM_LEDS);
    localparam int PER_W    = $clog2(MAX_PERIOD + SLOW_INC + 1);
    localparam int STEP_W   = $clog2(FAST_STEPS + (1 << LFSR_W));
    // The wait counter serves both the per-step period and the RESULT hold.
    localparam int WAIT_MAX = (MAX_PERIOD + SLOW_INC > HOLD_TICKS) ? (MAX_PERIOD + SLOW_INC) : HOLD_TICKS;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    state_e              state_q,      state_d;
    logic [POS_W-1:0]    pos_q,        pos_d;
    logic [NUM_LEDS-1:0] led_q,        led_d;
    logic [POS_W-1:0]    result_q,     result_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                rng_en_q,     rng_en_d;
    logic [WAIT_W-1:0]   wait_q,       wait_d;
    logic [STEP_W-1:0]   steps_q,      steps_d;
    logic [PER_W-1:0]    period_q,     period_d;
    logic                start_prev_q, start_prev_d;

    logic                tick;
    logic                start_edge;
    logic [WAIT_W:0]     wait_inc;
    logic                step;
    logic [POS_W-1:0]    pos_nxt;
    logic [PER_W-1:0]    per_nxt;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    assign start_edge = start_i && !start_prev_q;
    assign wait_inc   = {1'b0, wait_q} + (WAIT_W + 1)'(1);
    assign step       = tick && (wait_inc == (WAIT_W + 1)'(period_q));
    assign pos_nxt    = (pos_q == POS_W'(NUM_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
    assign per_nxt    = period_q + PER_W'(SLOW_INC);

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        led_d        = led_q;
        result_d     = result_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rng_en_d     = rng_en_q;
        wait_d       = wait_q;
        steps_d      = steps_q;
        period_d     = period_q;
        start_prev_d = start_i;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d  = FAST;
                    steps_d  = STEP_W'(FAST_STEPS) + STEP_W'(lfsr_i);
                    period_d = PER_W'(FAST_PERIOD);
                    wait_d   = '0;
                    busy_d   = 1'b1;
                    rng_en_d = 1'b0;
                end
            end
            FAST: begin
                if (step) begin
                    wait_d  = '0;
                    pos_d   = pos_nxt;
                    led_d   = NUM_LEDS'(1) << pos_nxt;
                    steps_d = steps_q - STEP_W'(1);
                    // The step that consumes the last count also hands over to SLOW.
                    if (steps_q <= STEP_W'(1)) begin
                        state_d  = SLOW;
                        period_d = PER_W'(FAST_PERIOD + SLOW_INC);
                    end
                end else if (tick) begin
                    wait_d = wait_inc[WAIT_W-1:0];
                end
            end
            SLOW: begin
                if (step) begin
                    wait_d   = '0;
                    pos_d    = pos_nxt;
                    led_d    = NUM_LEDS'(1) << pos_nxt;
                    period_d = per_nxt;
                    if (per_nxt > PER_W'(MAX_PERIOD)) begin
                        state_d  = RESULT;
                        result_d = pos_nxt;
                        done_d   = 1'b1;
                    end
                end else if (tick) begin
                    wait_d = wait_inc[WAIT_W-1:0];
                end
            end
            RESULT: begin
                if (tick) begin
                    if (wait_inc == (WAIT_W + 1)'(HOLD_TICKS)) begin
                        state_d  = IDLE;
                        wait_d   = '0;
                        busy_d   = 1'b0;
                        rng_en_d = 1'b1;
                    end else begin
                        wait_d = wait_inc[WAIT_W-1:0];
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                rng_en_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            led_q        <= NUM_LEDS'(1);
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rng_en_q     <= 1'b1;
            wait_q       <= '0;
            steps_q      <= '0;
            period_q     <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            led_q        <= led_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rng_en_q     <= rng_en_d;
            wait_q       <= wait_d;
            steps_q      <= steps_d;
            period_q     <= period_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign led_o    = led_q;
    assign result_o = result_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign rng_en_o = rng_en_q;

endmodule

// File: tb/tb_spin_ctrl.sv
// Bench for spin_ctrl with small timing parameters; reference model predicts each
// spin's step schedule from the game rules and checks outputs every clock.
// Stimulus: directed scenarios with random lfsr values and random lfsr noise mid-spin.
module tb_spin_ctrl;

    localparam int N    = 8;
    localparam int TD   = 2;
    localparam int FP   = 2;
    localparam int FS   = 8;
    localparam int SI   = 1;
    localparam int MAXP = 4;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [3:0] lfsr_i;
    logic       rng_en;
    logic [7:0] led;
    logic [2:0] result;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cur_pos = 0;
    int cur_res = 0;
    int step_t[$];

    always #5 clk = ~clk;

    spin_ctrl #(
        .NUM_LEDS    (N),
        .TICK_DIV    (TD),
        .FAST_PERIOD (FP),
        .FAST_STEPS  (FS),
        .SLOW_INC    (SI),
        .MAX_PERIOD  (MAXP),
        .HOLD_TICKS  (HOLD)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start_i),
        .lfsr_i   (lfsr_i),
        .rng_en_o (rng_en),
        .led_o    (led),
        .result_o (result),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clock edge (counted from the start-sampling edge) of every step of a spin.
    task automatic plan(input int lfsr);
        int t;
        int p;
        step_t.delete();
        t = 0;
        for (int i = 0; i < FS + lfsr; i++) begin
            t += FP * TD;
            step_t.push_back(t);
        end
        p = FP + SI;
        while (p <= MAXP) begin
            t += p * TD;
            step_t.push_back(t);
            p += SI;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_led"},    32'(led),    32'h01);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_rng_en"}, 32'(rng_en), 32'd1);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk("idle_busy",   32'(busy),   32'd0);
            chk("idle_done",   32'(done),   32'd0);
            chk("idle_rng_en", 32'(rng_en), 32'd1);
            chk("idle_led",    32'(led),    32'd1 << cur_pos);
            chk("idle_result", 32'(result), 32'(cur_res));
            lfsr_i = 4'($urandom_range(0, 15));
        end
    endtask

    // mode 0: single pulse; 1: extra pulses mid-spin; 2: start held high throughout.
    task automatic spin(input int lfsr, input int mode, input bit abort);
        int last, fin, nstep, pos, abort_n;
        bit aborted;
        plan(lfsr);
        last    = step_t[$];
        fin     = last + HOLD * TD;
        abort_n = abort ? last - 3 : -1;
        nstep   = 0;
        aborted = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        lfsr_i  = 4'(lfsr);
        start_i = 1'b1;
        for (int n = 0; n <= fin; n++) begin
            @(posedge clk);
            if (n == abort_n) begin
                #2 rst_n = 1'b0;
                #1 check_reset_vals("async_rst");
                @(negedge clk);
                chk("rst_no_done", 32'(done), 32'd0);
                start_i = 1'b0;
                rst_n   = 1'b1;
                cur_pos = 0;
                cur_res = 0;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            while (nstep < step_t.size() && step_t[nstep] <= n) nstep++;
            pos = (cur_pos + nstep) % N;
            chk("led",    32'(led),    32'd1 << pos);
            chk("busy",   32'(busy),   32'(n < fin));
            chk("done",   32'(done),   32'(n == last));
            chk("rng_en", 32'(rng_en), 32'(n >= fin));
            chk("result", 32'(result), 32'((n >= last) ? pos : cur_res));
            lfsr_i = 4'($urandom_range(0, 15));
            case (mode)
                0:       start_i = 1'b0;
                1:       start_i = (n % 5 == 2) && (n < fin);
                default: start_i = 1'b1;
            endcase
        end
        if (!aborted) begin
            cur_pos = (cur_pos + step_t.size()) % N;
            cur_res = cur_pos;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        lfsr_i  = 4'd0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Scenario 1: lfsr 5 -> 15 steps, lands on 7.
        spin(5, 0, 1'b0);
        chk("s1_result", 32'(result), 32'd7);
        chk("s1_led",    32'(led),    32'h80);
        idle(4);

        // Scenario 2: lfsr 0 from position 7 -> lands on 1.
        spin(0, 0, 1'b0);
        chk("s2_result", 32'(result), 32'd1);
        chk("s2_led",    32'(led),    32'h02);
        idle(4);

        // Scenario 3: extra start pulses through FAST/SLOW/RESULT are ignored.
        spin(5, 1, 1'b0);
        idle(4);

        // Scenario 4: start held high; no retrigger back in IDLE.
        spin(int'($urandom_range(0, 15)), 2, 1'b0);
        idle(8);
        spin(int'($urandom_range(0, 15)), 0, 1'b0);
        idle(3);

        // Scenario 5: asynchronous reset mid-SLOW.
        spin(5, 0, 1'b1);
        idle(4);

        // Random spins continuing from the reset position.
        for (int k = 0; k < 3; k++) begin
            spin(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b0);
            idle(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
